// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard.
package reg_scoreboard_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
    localparam int unsigned INFL_W   = 6;
    localparam int unsigned INFL_MAX = (1 << INFL_W) - 1;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [INFL_W-1:0] infl_t;

    // Total pending writes can exceed the output range; clamp to the top value.
    function automatic infl_t sat_infl(input int unsigned total);
        return (total > INFL_MAX) ? infl_t'(INFL_MAX) : infl_t'(total);
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / retire / flush bus between the ID stage and the scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic     issue_valid;
    logic     issue_regWrite;
    reg_idx_t issue_rd;
    reg_idx_t ID_rs1;
    reg_idx_t ID_rs2;
    logic     MEM_WB_regWrite;
    reg_idx_t MEM_WB_regRd;
    logic     flush_valid;
    reg_idx_t flush_rd;
    logic     stall;
    logic     busy_rs1;
    logic     busy_rs2;
    infl_t    inflight;
    logic     err;

    modport master (
        output issue_valid, issue_regWrite, issue_rd, ID_rs1, ID_rs2,
        output MEM_WB_regWrite, MEM_WB_regRd, flush_valid, flush_rd,
        input  stall, busy_rs1, busy_rs2, inflight, err
    );

    modport slave (
        input  issue_valid, issue_regWrite, issue_rd, ID_rs1, ID_rs2,
        input  MEM_WB_regWrite, MEM_WB_regRd, flush_valid, flush_rd,
        output stall, busy_rs1, busy_rs2, inflight, err
    );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register in-flight writer counter with clamping and error flagging.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_wb_i,
    input  logic dec_flush_i,
    output cnt_t cnt_o,
    output cnt_t cnt_nxt_o,
    output logic nonzero_o,
    output logic is_max_o,
    output logic err_pulse_o
);

    cnt_t                 cnt_q, cnt_d;
    logic [CNT_W+1:0]     sum;

    // Two extra bits hold the -2..max+1 result in two's complement:
    // top bit set = underflow, next bit set (top clear) = overflow.
    always_comb begin
        sum = {2'b00, cnt_q}
            + {{(CNT_W+1){1'b0}}, inc_i}
            - {{(CNT_W+1){1'b0}}, dec_wb_i}
            - {{(CNT_W+1){1'b0}}, dec_flush_i};
        cnt_d       = sum[CNT_W-1:0];
        err_pulse_o = 1'b0;
        if (sum[CNT_W+1]) begin
            cnt_d       = '0;
            err_pulse_o = 1'b1;
        end else if (sum[CNT_W]) begin
            cnt_d       = '1;
            err_pulse_o = 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
    assign nonzero_o = (cnt_q != '0);
    assign is_max_o  = (cnt_q == '1);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register hazard scoreboard: tracks pending writers per register
// and stalls ID when a source has a writer that forwarding cannot cover.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input logic          clk,
    input logic          rst,
    reg_scoreboard_if.slave sb
);

    cnt_t              cnt     [1:NUM_REGS-1];
    cnt_t              cnt_nxt [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] inc_oh, wb_oh, fl_oh;
    logic [NUM_REGS-1:1] nonzero, is_max, err_pulse;

    logic  issue_acc;
    logic  rs1_nz, rs2_nz, rd_max;
    cnt_t  rs1_cnt, rs2_cnt;
    logic  busy1, busy2, stall_c;
    infl_t inflight_q, inflight_d;
    logic  err_q, err_d;

    // x0 has no counter; decode only covers r = 1..NUM_REGS-1.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        assign inc_oh[r] = issue_acc && (sb.issue_rd == reg_idx_t'(r));
        assign wb_oh[r]  = sb.MEM_WB_regWrite && (sb.MEM_WB_regRd == reg_idx_t'(r));
        assign fl_oh[r]  = sb.flush_valid && (sb.flush_rd == reg_idx_t'(r));

        sb_counter u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc_oh[r]),
            .dec_wb_i    (wb_oh[r]),
            .dec_flush_i (fl_oh[r]),
            .cnt_o       (cnt[r]),
            .cnt_nxt_o   (cnt_nxt[r]),
            .nonzero_o   (nonzero[r]),
            .is_max_o    (is_max[r]),
            .err_pulse_o (err_pulse[r])
        );
    end

    // Source/destination lookups; index 0 reads as an empty register.
    always_comb begin
        rs1_nz  = 1'b0;
        rs2_nz  = 1'b0;
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_max  = 1'b0;
        if (sb.ID_rs1 != '0) begin
            rs1_nz  = nonzero[sb.ID_rs1];
            rs1_cnt = cnt[sb.ID_rs1];
        end
        if (sb.ID_rs2 != '0) begin
            rs2_nz  = nonzero[sb.ID_rs2];
            rs2_cnt = cnt[sb.ID_rs2];
        end
        if (sb.issue_rd != '0) rd_max = is_max[sb.issue_rd];
    end

    // Hazard and stall decision; a retiring last writer is covered by forwarding.
    always_comb begin
        busy1 = rs1_nz && !(sb.MEM_WB_regWrite && (sb.MEM_WB_regRd == sb.ID_rs1)
                            && (rs1_cnt == cnt_t'(1)));
        busy2 = rs2_nz && !(sb.MEM_WB_regWrite && (sb.MEM_WB_regRd == sb.ID_rs2)
                            && (rs2_cnt == cnt_t'(1)));
        stall_c   = sb.issue_valid && (busy1 || busy2 || (sb.issue_regWrite && rd_max));
        issue_acc = sb.issue_valid && !stall_c && sb.issue_regWrite && (sb.issue_rd != '0);
    end

    // Next totals: sum of next counter values, and sticky error accumulation.
    always_comb begin
        int unsigned total;
        total = 0;
        for (int unsigned r = 1; r < NUM_REGS; r++) total += 32'(cnt_nxt[r]);
        inflight_d = sat_infl(total);
        err_d      = err_q | (|err_pulse);
    end

    // Inflight total and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign sb.stall    = stall_c;
    assign sb.busy_rs1 = busy1;
    assign sb.busy_rs2 = busy2;
    assign sb.inflight = inflight_q;
    assign sb.err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs, a monitor pops and compares.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_scoreboard_if bus ();

    reg_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit stall;
        bit b1;
        bit b2;
        int infl;
        bit err;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference model: pending writer count per architectural register.
    int   mcnt[32];
    bit   merr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic int model_inflight();
        int s = 0;
        for (int r = 1; r < 32; r++) s += mcnt[r];
        return (s > 63) ? 63 : s;
    endfunction

    function automatic bit model_busy(input int rs, input bit wb, input int wrd);
        if (rs == 0 || mcnt[rs] == 0) return 1'b0;
        return !(wb && wrd == rs && mcnt[rs] == 1);
    endfunction

    task automatic idle_inputs();
        bus.issue_valid = 0; bus.issue_regWrite = 0; bus.issue_rd = 0;
        bus.ID_rs1 = 0; bus.ID_rs2 = 0;
        bus.MEM_WB_regWrite = 0; bus.MEM_WB_regRd = 0;
        bus.flush_valid = 0; bus.flush_rd = 0;
    endtask

    // One cycle of stimulus: drive after the edge, predict, advance model.
    task automatic step(input bit iv, input bit iw, input int ird, input int r1, input int r2,
                        input bit wb, input int wrd, input bit fv, input int frd);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        cyc++;
        bus.issue_valid = iv; bus.issue_regWrite = iw; bus.issue_rd = 5'(ird);
        bus.ID_rs1 = 5'(r1); bus.ID_rs2 = 5'(r2);
        bus.MEM_WB_regWrite = wb; bus.MEM_WB_regRd = 5'(wrd);
        bus.flush_valid = fv; bus.flush_rd = 5'(frd);
        e.cyc   = cyc;
        e.b1    = model_busy(r1, wb, wrd);
        e.b2    = model_busy(r2, wb, wrd);
        e.stall = iv && (e.b1 || e.b2 || (iw && ird != 0 && mcnt[ird] == 3));
        e.infl  = model_inflight();
        e.err   = merr;
        q.push_back(e);
        acc = iv && !e.stall && iw && ird != 0;
        for (int r = 1; r < 32; r++) begin
            int n;
            n = mcnt[r] + ((acc && ird == r) ? 1 : 0) - ((wb && wrd == r) ? 1 : 0)
                        - ((fv && frd == r) ? 1 : 0);
            if (n < 0) begin n = 0; merr = 1; end
            if (n > 3) begin n = 3; merr = 1; end
            mcnt[r] = n;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},    32'(bus.stall),    0);
        check({tag, "_busy1"},    32'(bus.busy_rs1), 0);
        check({tag, "_busy2"},    32'(bus.busy_rs2), 0);
        check({tag, "_inflight"}, 32'(bus.inflight), 0);
        check({tag, "_err"},      32'(bus.err),      0);
    endtask

    // Asynchronous reset asserted mid-cycle while inputs still present a hazard.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        bus.issue_valid = 1; bus.ID_rs1 = 5'd5; bus.issue_regWrite = 1; bus.issue_rd = 5'd5;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares each predicted cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("stall_c%0d", e.cyc),    32'(bus.stall),    32'(e.stall));
                check($sformatf("busy1_c%0d", e.cyc),    32'(bus.busy_rs1), 32'(e.b1));
                check($sformatf("busy2_c%0d", e.cyc),    32'(bus.busy_rs2), 32'(e.b2));
                check($sformatf("inflight_c%0d", e.cyc), 32'(bus.inflight), 32'(e.infl));
                check($sformatf("err_c%0d", e.cyc),      32'(bus.err),      32'(e.err));
            end
        end
    end

    initial begin
        int wrd;
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;
        idle_inputs();
        #3;
        check_reset_outputs("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // RAW hazard on x5, then same-cycle WB covers it.
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 0, 1, 5, 0, 0);
        // Two writers pending on x5, then reset discards them.
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mid_reset();

        // Saturate x7: fourth issue stalls, count holds, no error.
        for (int i = 0; i < 4; i++) step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // x9: issue+WB same cycle unchanged; WB+flush removes two.
        step(1, 1, 9, 0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 0, 0, 1, 9, 0, 0);
        step(1, 1, 9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 9, 1, 9);
        step(1, 0, 0, 9, 9, 0, 0, 0, 0);

        // x0 traffic ignored, no error.
        step(1, 1, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Underflow on x12 sets sticky error.
        step(0, 0, 0, 0, 0, 1, 12, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mid_reset();

        // Random mixed traffic over a small register window to create hazards.
        for (int i = 0; i < 400; i++) begin
            wrd = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 4 && mcnt[wrd] == 0; k++) wrd = $urandom_range(0, 7);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, wrd,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7));
        end

        begin
            int budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (q.size() > 0) check("drain_timeout", 32'(q.size()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
